// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the alu sequencer: command codes, alu oper codes,
//   sequencer state encoding and small decode helpers.
//   Commands (3-bit): ADD, SUB, MOVA, MOVB, CMP, MUL, CLR; code 7 is illegal.
//   Alu opers: ZERO, A, B, ADD, SUB.
package alu_seq_pkg;

  localparam int DATA_W      = 16;
  localparam int CMD_W       = 3;
  localparam int ALU_BIT_NUM = 3;

  localparam logic [CMD_W-1:0] CMD_ADD  = 3'd0;
  localparam logic [CMD_W-1:0] CMD_SUB  = 3'd1;
  localparam logic [CMD_W-1:0] CMD_MOVA = 3'd2;
  localparam logic [CMD_W-1:0] CMD_MOVB = 3'd3;
  localparam logic [CMD_W-1:0] CMD_CMP  = 3'd4;
  localparam logic [CMD_W-1:0] CMD_MUL  = 3'd5;
  localparam logic [CMD_W-1:0] CMD_CLR  = 3'd6;

  localparam logic [ALU_BIT_NUM-1:0] ALU_ZERO = 3'd0;
  localparam logic [ALU_BIT_NUM-1:0] ALU_A    = 3'd1;
  localparam logic [ALU_BIT_NUM-1:0] ALU_B    = 3'd2;
  localparam logic [ALU_BIT_NUM-1:0] ALU_ADD  = 3'd3;
  localparam logic [ALU_BIT_NUM-1:0] ALU_SUB  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FLAG = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // MUL is only legal when the multiplier is enabled at build time.
  function automatic logic cmd_legal(input logic [CMD_W-1:0] cmd, input logic mul_en);
    logic ok;
    ok = 1'b0;
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_MOVA, CMD_MOVB, CMD_CMP, CMD_CLR: ok = 1'b1;
      CMD_MUL: ok = mul_en;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // MUL with a zero count collapses to a single ALU_ZERO cycle.
  function automatic logic [ALU_BIT_NUM-1:0] cmd_oper(input logic [CMD_W-1:0] cmd,
                                                      input logic b_zero);
    logic [ALU_BIT_NUM-1:0] op;
    op = ALU_ZERO;
    case (cmd)
      CMD_ADD:  op = ALU_ADD;
      CMD_SUB:  op = ALU_SUB;
      CMD_MOVA: op = ALU_A;
      CMD_MOVB: op = ALU_B;
      CMD_CMP:  op = ALU_SUB;
      CMD_MUL:  op = b_zero ? ALU_ZERO : ALU_ADD;
      default:  op = ALU_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_seq_cnt.sv
// alu_seq_cnt
//   16-bit loadable down-counter tracking remaining EXEC iterations.
//   Ports: clk, rst (sync, active-high), clear (sync discard), load/load_value,
//          dec (decrement, saturates at zero), is_zero.
module alu_seq_cnt
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_value,
  input  logic              dec,
  output logic              is_zero
);

  logic [DATA_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 16'd1;
    end
  end

  assign is_zero = (count == '0);

endmodule

// File: rtl/alu_seq.sv
// alu_seq
//   Multi-cycle sequencer in front of a 16-bit alu. Takes one command over a
//   valid/ready request port, drives the alu, waits out the alu's registered
//   zero flag and returns result + flags over a valid/ready response port.
//   Ports: clk, rst, flush; req_valid/req_ready/req_cmd/req_a/req_b;
//          resp_valid/resp_ready/resp_data/resp_zero/resp_ovf/resp_err; busy;
//          alu_a/alu_b/alu_oper to the alu, alu_result/alu_zero from the alu.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter bit                     MUL_EN    = 1'b1,
  parameter logic [ALU_BIT_NUM-1:0] IDLE_OPER = ALU_ZERO
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CMD_W-1:0]       req_cmd,
  input  logic [DATA_W-1:0]      req_a,
  input  logic [DATA_W-1:0]      req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   resp_zero,
  output logic                   resp_ovf,
  output logic                   resp_err,
  output logic                   busy,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [ALU_BIT_NUM-1:0] alu_oper,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic                   alu_zero
);

  state_e            state;
  logic [DATA_W-1:0] acc;
  logic              ovf;
  logic              is_mul;
  logic              is_cmp;
  logic              cnt_zero;
  logic              accept;
  logic              mul_req;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = (state == ST_IDLE) && req_valid && !flush;
  assign mul_req   = (req_cmd == CMD_MUL) && (req_b != '0);

  // The counter holds the iterations left after the current EXEC cycle, so
  // a MUL loads b-1 and every other command loads 0; EXEC ends on is_zero.
  alu_seq_cnt u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear      (flush),
    .load       (accept),
    .load_value (mul_req ? (req_b - 16'd1) : 16'd0),
    .dec        ((state == ST_EXEC) && !cnt_zero),
    .is_zero    (cnt_zero)
  );

  // Sequencer FSM. For MUL, alu_a doubles as the accumulator fed back to the
  // alu; it is frozen on the last iteration so FLAG sees unchanged operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      acc        <= '0;
      ovf        <= 1'b0;
      is_mul     <= 1'b0;
      is_cmp     <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_zero  <= 1'b0;
      resp_ovf   <= 1'b0;
      resp_err   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_oper   <= IDLE_OPER;
    end else if (flush) begin
      state      <= ST_IDLE;
      acc        <= '0;
      ovf        <= 1'b0;
      resp_valid <= 1'b0;
      alu_oper   <= IDLE_OPER;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            acc    <= '0;
            ovf    <= 1'b0;
            is_cmp <= (req_cmd == CMD_CMP);
            is_mul <= mul_req;
            if (!cmd_legal(req_cmd, MUL_EN)) begin
              state      <= ST_DONE;
              resp_valid <= 1'b1;
              resp_data  <= '0;
              resp_zero  <= 1'b0;
              resp_ovf   <= 1'b0;
              resp_err   <= 1'b1;
            end else begin
              state    <= ST_EXEC;
              resp_err <= 1'b0;
              alu_oper <= cmd_oper(req_cmd, req_b == '0);
              if (req_cmd == CMD_MUL) begin
                alu_a <= '0;
                alu_b <= req_a;
              end else begin
                alu_a <= req_a;
                alu_b <= req_b;
              end
            end
          end
        end
        ST_EXEC: begin
          acc <= alu_result;
          if (is_mul) begin
            if (alu_result < alu_a) begin
              ovf <= 1'b1;
            end
            if (!cnt_zero) begin
              alu_a <= alu_result;
            end
          end
          if (cnt_zero) begin
            state <= ST_FLAG;
          end
        end
        ST_FLAG: begin
          state      <= ST_DONE;
          resp_valid <= 1'b1;
          resp_data  <= is_cmp ? '0 : acc;
          resp_zero  <= alu_zero;
          resp_ovf   <= ovf;
          alu_oper   <= IDLE_OPER;
        end
        ST_DONE: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
